// File: rtl/cordic_pkg.sv
// cordic_pkg: Q-format constants, angle thresholds and atan table shared by the sequencer,
// the CORDIC pipeline and its models.
package cordic_pkg;
    localparam int DATA_W = 16;
    localparam int STAGES = 6;
    localparam logic [15:0] K_GAIN = 16'h26DD;
    localparam logic [15:0] ANGLE_90 = 16'h2D00;
    localparam logic [15:0] ANGLE_180 = 16'h5A00;
    localparam logic [15:0] ANGLE_270 = 16'h8700;
    localparam logic [15:0] ANGLE_360 = 16'hB400;
    // atan(2^-i) in Q8.8 degrees: 45, 26.57, 14.04, 7.13, 3.58, 1.79
    localparam logic [15:0] ATAN_Q88 [STAGES] = '{16'd11520, 16'd6801, 16'd3593, 16'd1824, 16'd916, 16'd458};

    function automatic logic [15:0] sat_neg(input logic [15:0] v);
        return (v == 16'h8000) ? 16'h7FFF : -v;
    endfunction
endpackage

// File: rtl/cordic_range_reduce.sv
// cordic_range_reduce: folds a Q9.7 full-circle angle into (-90,+90] deg as a Q8.8 target
// plus a flag saying the result must be negated.
module cordic_range_reduce
    import cordic_pkg::*;
(
    input  logic [15:0] angle_i,
    output logic [15:0] target_o,
    output logic        neg_o
);
    logic [15:0] a;
    logic [15:0] r;

    always_comb begin
        a = (angle_i >= ANGLE_360) ? angle_i - ANGLE_360 : angle_i;
        neg_o = (a > ANGLE_90) && (a <= ANGLE_270);
        r = (a <= ANGLE_90) ? a : (a <= ANGLE_270) ? a - ANGLE_180 : a - ANGLE_360;
        target_o = r << 1;
    end
endmodule

// File: rtl/cordic_seq_ctrl.sv
// cordic_seq_ctrl: request/response sequencer around the external CORDIC pipeline; tracks
// per-slot valid/sign alongside the pipeline and applies sign correction at the output.
module cordic_seq_ctrl
    import cordic_pkg::*;
#(
    parameter int          PIPE_DEPTH = 5,
    parameter int          W          = DATA_W,
    parameter logic [W-1:0] K_INIT    = K_GAIN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] angle_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] cos_out,
    output logic [W-1:0] sin_out,
    output logic         busy,
    output logic         cordic_reg_en,
    output logic [W-1:0] cordic_x_init,
    output logic [W-1:0] cordic_y_init,
    output logic [W-1:0] cordic_target_angle,
    input  logic [W-1:0] cordic_x_out,
    input  logic [W-1:0] cordic_y_out
);
    logic                stall;
    logic                en;
    logic                neg;
    logic [W-1:0]        target;
    logic [PIPE_DEPTH:0] v_q;
    logic [PIPE_DEPTH:0] n_q;
    logic                out_valid_q;
    logic [W-1:0]        cos_q, sin_q, cos_d, sin_d;
    logic [W-1:0]        x_init_q, y_init_q, target_q;

    cordic_range_reduce u_range_reduce (
        .angle_i  (angle_in),
        .target_o (target),
        .neg_o    (neg)
    );

    always_comb begin
        stall = out_valid_q && !out_ready;
        en = !stall && !rst;
        cos_d = n_q[PIPE_DEPTH] ? sat_neg(cordic_x_out) : cordic_x_out;
        sin_d = n_q[PIPE_DEPTH] ? sat_neg(cordic_y_out) : cordic_y_out;
    end

    // A single enable moves stage 0, the tracker and the output register in lockstep with the pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q         <= '0;
            n_q         <= '0;
            out_valid_q <= 1'b0;
            cos_q       <= '0;
            sin_q       <= '0;
            x_init_q    <= '0;
            y_init_q    <= '0;
            target_q    <= '0;
        end else if (en) begin
            x_init_q    <= K_INIT;
            y_init_q    <= '0;
            target_q    <= target;
            v_q         <= {v_q[PIPE_DEPTH-1:0], in_valid && in_ready};
            n_q         <= {n_q[PIPE_DEPTH-1:0], neg};
            out_valid_q <= v_q[PIPE_DEPTH];
            if (v_q[PIPE_DEPTH]) begin
                cos_q <= cos_d;
                sin_q <= sin_d;
            end
        end
    end

    assign in_ready            = en;
    assign cordic_reg_en       = en;
    assign out_valid           = out_valid_q;
    assign cos_out             = cos_q;
    assign sin_out             = sin_q;
    assign busy                = |v_q || out_valid_q;
    assign cordic_x_init       = x_init_q;
    assign cordic_y_init       = y_init_q;
    assign cordic_target_angle = target_q;
endmodule
